i2c_slave_target: RTL and testbench
===================================

Name: i2c_slave_target

Overview:
- Clocked I2C target (slave) endpoint; the responder at the far end of the bus from the team's I2C master.
- Oversamples SCL/SDA in the system clock domain and detects START, repeated START and STOP.
- Matches a 7-bit address, receives write bytes with ACK, and transmits read bytes from a user byte interface.
- Drives SDA open-drain only (low or Z); never drives SCL, so no clock stretching.

Parameters:
- ADDR, 7'h50, own 7-bit bus address.
- SYNC_STAGES, 2, synchronizer flops on SCL/SDA (minimum 2).

Ports:
- clk  input  1  system clock; must be ≥10× SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- SCL  input  1  bus clock from master.
- SDA  inout  1  bus data; driven 1'b0 or 1'bz only.
- rx_data  output  8  last received write byte; held until the next byte completes.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  8  byte to transmit on read; sampled per tx_req rule.
- tx_req  output  1  one-clk pulse requesting the next read byte.
- addressed  output  1  high from address ACK until STOP or repeated START.
- busy  output  1  high between any START and STOP on the bus.

Behaviour:
- Clock/reset: one clock `clk`; `rst` asynchronous, active-high.
- Reset values: rx_data=0, rx_valid=0, tx_req=0, addressed=0, busy=0, SDA released (Z), state IDLE, bit counter 0.
- Input path: SCL/SDA pass through SYNC_STAGES flops plus one history flop.
  - Rise/fall events are single-clk pulses derived from the synchronized values.
  - All decisions use synchronized values; latency from pin to event is SYNC_STAGES+1 clks.
- Bus conditions:
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Both are checked in every state and take priority over bit events in the same clk.
- Bit timing: sample SDA on the SCL rise event; change the SDA drive only on the SCL fall event.
- States:
  - IDLE: wait for START → ADDR; busy=1.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W), 3-bit counter.
    - After the 8th rise: if address == ADDR → ADDR_ACK; else → WAIT_STOP with SDA released.
  - ADDR_ACK: on the SCL fall, drive SDA=0 and set addressed=1. Hold low through one SCL high.
    - If R/W=1: pulse tx_req on the ACK SCL rise.
    - On the next SCL fall: release SDA if R/W=0 → WRITE; if R/W=1, load tx_data into the shift register → READ.
  - WRITE: shift 8 bits. On the 8th rise, update rx_data and pulse rx_valid the same clk → WR_ACK.
  - WR_ACK: drive SDA=0 on the SCL fall, release on the next SCL fall → WRITE. Every write byte is ACKed.
  - READ:
    - Put the MSB on SDA at load time; shift on each subsequent SCL fall.
    - Drive 0 as 0; drive 1 as Z (released).
    - After the 8th bit's SCL fall, release SDA → RD_ACK.
  - RD_ACK: sample SDA on the SCL rise.
    - 0 (ACK): pulse tx_req; on the SCL fall, load tx_data → READ.
    - 1 (NACK): → WAIT_STOP.
  - WAIT_STOP: SDA released; ignore bits; exit only on STOP or START.
- STOP from any state: release SDA, addressed=0, busy=0, → IDLE. A partial byte is discarded and no rx_valid is raised.
- Repeated START from any state: release SDA, addressed=0, clear bit counter, → ADDR; busy stays 1.
- tx_data contract: user holds tx_data stable from the tx_req pulse until the following SCL fall.
- Asynchronous reset mid-transfer: SDA goes to Z immediately (combinational from the reset flop), without waiting for a clk edge.
- The general call address (7'h00) is not recognised; 10-bit addressing is not supported.

Decomposition:
- Package i2c_pkg holds:
  - state encoding (IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, WAIT_STOP);
  - ACK=1'b0 and NACK=1'b1;
  - RW_WRITE=1'b0 and RW_READ=1'b1.
- Sub-module i2c_line_sync: SYNC_STAGES synchronizer, history flop, and rise/fall pulse outputs. Instantiated once each for SCL and SDA.
- START/STOP detection and the FSM live in the top module.
- The SDA tristate is a single continuous assignment at the top level.

Test Plan:
- Write, address 0xA0 then data 0x3C, then STOP → target ACKs both bytes (SDA low during both 9th clocks); rx_valid pulses once with rx_data=0x3C; addressed and busy return to 0 after STOP.
- Wrong address 0xA2 followed by data 0x55 → SDA never driven low; no rx_valid; state WAIT_STOP until STOP.
- Read 0xA1 with tx_data=0x96, master NACK → SDA bits 1,0,0,1,0,1,1,0; exactly one tx_req; SDA released after NACK; STOP → IDLE.
- Read of 2 bytes (0x96 with master ACK, then 0x0F with NACK) → two tx_req pulses; second byte on the wire = 0x0F.
- Write 0xA0 then 4 bits of data, then repeated START, then 0xA1 → partial byte dropped with no rx_valid; read ACKed; tx_req pulses.
- rst asserted while the target holds SDA=0 in ADDR_ACK → SDA is Z in the same cycle; all outputs at reset values; the next transaction (0xA0, 0x11) completes with rx_data=0x11.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, ACK/NACK and R/W bit values,
// plus the address-match helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WR_ACK,
    S_READ,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Address frame is {addr[6:0], rw}; the general call address never matches.
  function automatic logic addr_hit(input logic [7:0] frame, input logic [6:0] own);
    return (frame[7:1] == own) && (frame[7:1] != 7'h00);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one bus line, with a history flop and single-clk rise/fall pulses.
// Pulses appear STAGES clks after the pin moves, so the FSM acts on them at STAGES+1; no backpressure.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  // Reset to the idle-bus level (pulled high) so no spurious edges appear when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, ACKed writes, reads from a byte port.
// SDA changes only on synchronized SCL falls; SCL is never stretched, so the user must meet tx_data timing.
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] shift_in;
  logic       rw;
  logic       ack_held;
  logic       sda_oe;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (SCL),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (SDA),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;
  assign shift_in  = {shreg[6:0], sda_lvl};

  // Gating with rst releases the line within the same cycle the reset arrives.
  assign SDA = (sda_oe && !rst) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw        <= RW_WRITE;
      ack_held  <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addressed <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det) begin
        state     <= S_IDLE;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
      end else if (start_det) begin
        state     <= S_ADDR;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
        busy      <= 1'b1;
        bit_cnt   <= '0;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise) begin
              shreg   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw       <= shift_in[0];
                ack_held <= 1'b0;
                state    <= addr_hit(shift_in, ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
              end
            end
          end
          // ack_held separates the fall that starts the ACK slot from the fall that ends it.
          S_ADDR_ACK: begin
            if (scl_rise && ack_held && rw == RW_READ) begin
              tx_req <= 1'b1;
            end
            if (scl_fall && !ack_held) begin
              sda_oe    <= 1'b1;
              addressed <= 1'b1;
              ack_held  <= 1'b1;
            end else if (scl_fall) begin
              bit_cnt <= '0;
              if (rw == RW_READ) begin
                shreg  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= S_READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= S_WRITE;
              end
            end
          end
          S_WRITE: begin
            if (scl_rise) begin
              shreg   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= shift_in;
                rx_valid <= 1'b1;
                ack_held <= 1'b0;
                state    <= S_WR_ACK;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall && !ack_held) begin
              sda_oe   <= 1'b1;
              ack_held <= 1'b1;
            end else if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= S_WRITE;
            end
          end
          S_READ: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe   <= 1'b0;
                ack_held <= 1'b0;
                state    <= S_RD_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == ACK) begin
                tx_req   <= 1'b1;
                ack_held <= 1'b1;
              end else begin
                state <= S_WAIT_STOP;
              end
            end else if (scl_fall && ack_held) begin
              shreg   <= tx_data;
              sda_oe  <= ~tx_data[7];
              bit_cnt <= '0;
              state   <= S_READ;
            end
          end
          S_WAIT_STOP: sda_oe <= 1'b0;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bit-banged master runs table rows, hand-written corner sequences
// and random transactions, each judged against expectations derived from the protocol rules.
module tb_i2c_slave_target;

  localparam int Q = 8;  // clks per quarter SCL period

  typedef struct packed {
    logic [7:0]      addr;
    logic [2:0]      n;
    logic [3:0][7:0] d;
    logic            exp_ack;
    logic [2:0]      exp_nrx;
    logic [2:0]      exp_nreq;
    logic [3:0][7:0] exp_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'hEE;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addressed, busy;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_target #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .SCL       (scl),
    .SDA       (sda),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .addressed (addressed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses, logs received bytes, answers tx_req from tx_src.
  int              rx_total = 0, req_total = 0, low_total = 0, req_base = 0;
  logic [7:0]      rx_log [0:255];
  logic [3:0][7:0] tx_src = '0;
  logic [1:0]      tx_idx;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[8'(rx_total)] = rx_data;
      rx_total++;
    end
    if (tx_req) begin
      tx_idx  = 2'(req_total - req_base);
      tx_data = tx_src[tx_idx];
      req_total++;
    end
    if (!m_sda_low && sda === 1'b0) low_total++;
  end

  task automatic quarter();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; quarter();
    scl = 1'b1;       quarter();
    m_sda_low = 1'b1; quarter();
    scl = 1'b0;       quarter();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; quarter();
    scl = 1'b1;       quarter();
    m_sda_low = 1'b0; quarter();
    quarter();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda_low = ~b; quarter();
    scl = 1'b1;     quarter();
    @(negedge clk);
    s = sda;
    quarter();
    scl = 1'b0;     quarter();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(mack, s);
  endtask

  // d and e list byte 0 in the top bits so table rows read left to right.
  function automatic vec_t mk(input logic [7:0] a, input int n, input logic [31:0] d, input logic ack,
                              input int nrx, input int nreq, input logic [31:0] e);
    vec_t v;
    v.addr     = a;
    v.n        = 3'(n);
    v.exp_ack  = ack;
    v.exp_nrx  = 3'(nrx);
    v.exp_nreq = 3'(nreq);
    for (int i = 0; i < 4; i++) begin
      v.d[i]     = d[31-8*i -: 8];
      v.exp_b[i] = e[31-8*i -: 8];
    end
    return v;
  endfunction

  // Reference: only 0x50 answers; writes are all ACKed and delivered, reads return
  // one requested byte per byte clocked; anything else sees a silent bus (0xFF).
  function automatic vec_t model(input logic [6:0] a7, input logic rw, input int n, input logic [31:0] d);
    logic        hit;
    logic [31:0] e;
    hit = (a7 == 7'h50);
    e   = (rw && !hit) ? 32'hFFFF_FFFF : d;
    return mk({a7, rw}, n, d, !hit, (hit && !rw) ? n : 0, (hit && rw) ? n : 0, e);
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    logic       a;
    logic [7:0] b;
    int         rx0, req0, low0;
    rx0 = rx_total; req0 = req_total; low0 = low_total;
    req_base = req_total;
    tx_src   = v.d;
    bus_start();
    write_byte(v.addr, a);
    chk($sformatf("v%0d addr_ack", id), 32'(a), 32'(v.exp_ack));
    chk($sformatf("v%0d addressed_mid", id), 32'(addressed), 32'(!v.exp_ack));
    chk($sformatf("v%0d busy_mid", id), 32'(busy), 32'd1);
    for (int i = 0; i < int'(v.n); i++) begin
      if (!v.addr[0]) begin
        write_byte(v.d[i], a);
        chk($sformatf("v%0d data_ack%0d", id, i), 32'(a), 32'(v.exp_ack));
      end else begin
        read_byte((i == int'(v.n) - 1) ? 1'b1 : 1'b0, b);
        chk($sformatf("v%0d rd_byte%0d", id, i), 32'(b), 32'(v.exp_b[i]));
      end
    end
    if (v.addr[0]) begin
      @(negedge clk);
      chk($sformatf("v%0d sda_released", id), 32'(sda), 32'd1);
    end
    bus_stop();
    chk($sformatf("v%0d rx_count", id), 32'(rx_total - rx0), 32'(v.exp_nrx));
    for (int i = 0; i < int'(v.exp_nrx); i++)
      chk($sformatf("v%0d rx_byte%0d", id, i), 32'(rx_log[8'(rx0 + i)]), 32'(v.exp_b[i]));
    if (v.exp_nrx != 0)
      chk($sformatf("v%0d rx_data_held", id), 32'(rx_data), 32'(v.exp_b[v.exp_nrx - 3'd1]));
    chk($sformatf("v%0d tx_req_count", id), 32'(req_total - req0), 32'(v.exp_nreq));
    chk($sformatf("v%0d addressed_end", id), 32'(addressed), 32'd0);
    chk($sformatf("v%0d busy_end", id), 32'(busy), 32'd0);
    if (v.exp_ack) chk($sformatf("v%0d sda_never_low", id), 32'(low_total - low0), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [7];
    logic       a, s;
    logic [7:0] b, frame;
    logic [6:0] a7;
    int         rx0, req0, w;

    tbl[0] = mk(8'hA0, 1, 32'h3C00_0000, 1'b0, 1, 0, 32'h3C00_0000);
    tbl[1] = mk(8'hA2, 1, 32'h5500_0000, 1'b1, 0, 0, 32'h0000_0000);
    tbl[2] = mk(8'hA1, 1, 32'h9600_0000, 1'b0, 0, 1, 32'h9600_0000);
    tbl[3] = mk(8'hA1, 2, 32'h960F_0000, 1'b0, 0, 2, 32'h960F_0000);
    tbl[4] = mk(8'hA0, 3, 32'h00FF_A500, 1'b0, 3, 0, 32'h00FF_A500);
    tbl[5] = mk(8'hA3, 1, 32'h1200_0000, 1'b1, 0, 0, 32'hFF00_0000);
    tbl[6] = mk(8'h00, 1, 32'h7700_0000, 1'b1, 0, 0, 32'h0000_0000);

    repeat (3) @(negedge clk);
    chk("reset rx_data", 32'(rx_data), 32'd0);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    chk("reset tx_req", 32'(tx_req), 32'd0);
    chk("reset addressed", 32'(addressed), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset sda", 32'(sda), 32'd1);
    rst = 1'b0;
    quarter(); quarter();

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Partial write byte abandoned by a repeated START, then a read.
    rx0 = rx_total; req0 = req_total;
    req_base = req_total;
    tx_src   = {8'h00, 8'h00, 8'h00, 8'h5A};
    bus_start();
    write_byte(8'hA0, a);
    chk("rs addr_ack", 32'(a), 32'd0);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
    chk("rs addressed_before", 32'(addressed), 32'd1);
    bus_start();
    chk("rs addressed_after", 32'(addressed), 32'd0);
    chk("rs busy_after", 32'(busy), 32'd1);
    write_byte(8'hA1, a);
    chk("rs read_addr_ack", 32'(a), 32'd0);
    read_byte(1'b1, b);
    chk("rs rd_byte", 32'(b), 32'h5A);
    bus_stop();
    chk("rs rx_count", 32'(rx_total - rx0), 32'd0);
    chk("rs tx_req_count", 32'(req_total - req0), 32'd1);

    // Reset while the target holds the address ACK low.
    frame = 8'hA0;
    bus_start();
    for (int i = 7; i >= 0; i--) clk_bit(frame[i], s);
    m_sda_low = 1'b0;
    w = 0;
    while (sda !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("rst ack_driven", 32'(sda), 32'd0);
    chk("rst addressed_pre", 32'(addressed), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst sda_z", 32'(sda), 32'd1);
    chk("rst rx_data", 32'(rx_data), 32'd0);
    chk("rst rx_valid", 32'(rx_valid), 32'd0);
    chk("rst tx_req", 32'(tx_req), 32'd0);
    chk("rst addressed", 32'(addressed), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    scl = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    quarter();
    run_vec(100, mk(8'hA0, 1, 32'h1100_0000, 1'b0, 1, 0, 32'h1100_0000));

    for (int i = 0; i < 10; i++) begin
      a7 = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
      run_vec(200 + i, model(a7, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
